// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the execution-stage ALU and the ALU
//               decoder: datapath width, ALUControl op codes, FSM state
//               encodings and a shift-op classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN = 32;

    // ALUControl op codes (shared with the ALU decoder)
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    // Execution FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb_core
// Description : Purely combinational ALU datapath: ADD, SUB, AND, OR, signed
//               SLT. Unknown codes execute as ADD.
//               Build option ALU_FAST_SHIFT_EN: when defined, SLL/SRL/SRA are
//               computed here by a barrel shifter; otherwise shift ops pass
//               i_a through unchanged (the iterative shifter in the parent
//               starts from that value, and it is the final answer when the
//               shift amount is zero).
// Ports       : i_op [3:0]   ALUControl op code
//               i_a  [XLEN]  operand A
//               i_b  [XLEN]  operand B ([4:0] = shift amount)
//               o_y  [XLEN]  result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb_core
    import alu_pkg::*;
(
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_y
);

    logic w_lt;

    assign w_lt = ($signed(i_a) < $signed(i_b));

    always_comb begin
        o_y = i_a + i_b;
        case (i_op)
            ALU_SUB: o_y = i_a - i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_SLT: o_y = {{(XLEN-1){1'b0}}, w_lt};
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL: o_y = i_a << i_b[4:0];
            ALU_SRL: o_y = i_a >> i_b[4:0];
            ALU_SRA: o_y = XLEN'($signed(i_a) >>> i_b[4:0]);
`else
            ALU_SLL, ALU_SRL, ALU_SRA: o_y = i_a;
`endif
            default: o_y = i_a + i_b;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execution-stage ALU with valid/ready handshakes on input and
//               output. Arithmetic/logic ops complete in one cycle; shifts
//               run one bit per cycle through the SHIFT state.
//               Build option ALU_FAST_SHIFT_EN: when defined, shifts use the
//               single-cycle barrel shifter in alu_comb_core and SHIFT is
//               never entered.
// Ports       : clk, rst        clock / synchronous active-high reset
//               in_valid/in_ready    request handshake (ready only in IDLE)
//               ALUControl [3:0]     op code, sampled at accept
//               src_a, src_b [XLEN]  operands, sampled at accept
//               out_valid/out_ready  result handshake
//               result [XLEN], zero  result and (result == 0) while valid
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALUControl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic [4:0]      r_count;
    logic [3:0]      r_op;

    logic            w_accept;
    logic            w_start_shift;
    logic            w_last_shift;
    logic [XLEN-1:0] w_core_y;
    logic [XLEN-1:0] w_shift_y;

    alu_comb_core u_core (
        .i_op (ALUControl),
        .i_a  (src_a),
        .i_b  (src_b),
        .o_y  (w_core_y)
    );

    assign w_accept = in_valid && (r_state == ST_IDLE);

`ifdef ALU_FAST_SHIFT_EN
    assign w_start_shift = 1'b0;
`else
    // A zero shift amount finishes in one cycle with src_a as the result.
    assign w_start_shift = is_shift_op(ALUControl) && (src_b[4:0] != 5'd0);
`endif

    assign w_last_shift = (r_count == 5'd1);

    // One-bit step of the iterative shifter; only shift codes reach SHIFT.
    always_comb begin
        case (r_op)
            ALU_SLL: w_shift_y = {r_result[XLEN-2:0], 1'b0};
            ALU_SRL: w_shift_y = {1'b0, r_result[XLEN-1:1]};
            default: w_shift_y = {r_result[XLEN-1], r_result[XLEN-1:1]};
        endcase
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_start_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_last_shift) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        result    = r_result;
        zero      = r_zero && (r_state == ST_DONE);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_count  <= 5'd0;
            r_op     <= ALU_ADD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_start_shift) begin
                            r_result <= src_a;
                            r_count  <= src_b[4:0];
                            r_op     <= ALUControl;
                        end else begin
                            r_result <= w_core_y;
                            r_zero   <= (w_core_y == '0);
                        end
                    end
                end
                ST_SHIFT: begin
                    r_result <= w_shift_y;
                    r_count  <= r_count - 5'd1;
                    if (w_last_shift) begin
                        r_zero <= (w_shift_y == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
